bp_me_mem_cmd_arbiter: RTL and testbench
========================================

// Module: bp_me_mem_cmd_arbiter
// PURPOSE
//  Shares one BedRock lite memory port (mem_cmd_o/mem_resp_i) between num_req_p command sources,
//  e.g. core DRAM traffic and host-side I/O in the tethered testbench. Round-robin arbitration on
//  commands; an order FIFO of granted requester IDs steers the in-order responses back to their source.
//  Bounds outstanding requests to max_outstanding_p.
// PARAMETERS
//  msg_width_p        1      width of one lite mem message (header+payload+data); set to cce_mem_msg_width_lp
//  num_req_p          2      number of requesters, >=2
//  max_outstanding_p  8      order FIFO depth; max commands issued but not yet answered, power of 2
// PORTS
//  clk_i            in   1                      clock
//  reset_n_i        in   1                      asynchronous reset, active-low
//  req_cmd_i        in   num_req_p*msg_width_p  per-requester command, requester r at [r*msg_width_p +: msg_width_p]
//  req_cmd_v_i      in   num_req_p              per-requester command valid
//  req_cmd_ready_o  out  num_req_p              per-requester ready; a transfer is v&ready
//  req_resp_o       out  msg_width_p            response, broadcast to all requesters
//  req_resp_v_o     out  num_req_p              one-hot response valid; bit = owning requester
//  req_resp_yumi_i  in   num_req_p              per-requester response consume
//  mem_cmd_o        out  msg_width_p            command to memory
//  mem_cmd_v_o      out  1                      command valid
//  mem_cmd_ready_i  in   1                      memory ready; a transfer is v&ready
//  mem_resp_i       in   msg_width_p            response from memory, in command order
//  mem_resp_v_i     in   1                      response valid
//  mem_resp_yumi_o  out  1                      response consumed
// BEHAVIOUR
//  Reset (reset_n_i=0, async): all outputs 0; state=IDLE; rr pointer=0; FIFO empty; count=0.
//  Outstanding responses are discarded, so the memory side must be reset in the same window.
//  FSM states: IDLE, LOCK.
//   IDLE: if any req_cmd_v_i and FIFO not full, grant = first valid at or after rr pointer (wrapping).
//         mem_cmd_o/mem_cmd_v_o = granted requester, combinational, zero added latency.
//         If mem_cmd_ready_i: transfer completes and req_cmd_ready_o[grant]=1. Push the grant ID;
//         rr pointer <= grant+1 mod num_req_p; stay in IDLE.
//         Else: latch the grant and go to LOCK.
//   LOCK: the latched requester stays selected, whatever the other valids are; no re-arbitration.
//         When mem_cmd_ready_i=1, transfer, push, advance rr pointer, go to IDLE.
//  req_cmd_ready_o is nonzero only for the granted bit and only in the transfer cycle, so ready is
//  never given to a non-granted requester.
//  Full: count==max_outstanding_p means mem_cmd_v_o=0 and all readies=0. A pop in the same cycle does
//  not unblock the push; the push occurs next cycle. LOCK is never entered while full.
//  Response path: with FIFO head h, req_resp_v_o = mem_resp_v_i & ~empty, placed at one-hot bit h.
//  req_resp_o = mem_resp_i. mem_resp_yumi_o = req_resp_v_o[h] & req_resp_yumi_i[h]. Pop on yumi.
//  Zero latency. Yumi on a non-head bit is ignored.
//  mem_resp_v_i while empty: not consumed and all valids held 0; the simulation assertion fires.
//  Simultaneous push+pop: count unchanged; FIFO pointers wrap mod max_outstanding_p.
//  Width rules: the count is $clog2(max_outstanding_p+1) bits; IDs and rr pointer are
//  $clog2(num_req_p) bits, and the pointer wraps at num_req_p-1 -> 0.
//  Assertions: no push when full, no pop when empty, the req_cmd_v_i of the LOCK requester must not
//  drop before transfer, and req_resp_yumi_i only with the matching req_resp_v_o.
// STRUCTURE
//  bp_me_pkg: typedef enum logic {e_arb_idle, e_arb_lock} bp_me_arb_state_e.
//  Sub-module bp_me_arb_order_fifo (async active-low reset, 1r1w, depth max_outstanding_p,
//  width $clog2(num_req_p), exposes full/empty/count). Arbiter FSM and steering logic are top-level.
// TESTING
//  1 Reset mid-LOCK with 3 outstanding -> all outputs 0 immediately; after release count=0 and a
//    new cmd from req1 is granted first.
//  2 Both requesters valid, mem_cmd_ready_i=1 continuously -> grants alternate 0,1,0,1. Responses
//    returned in order assert req_resp_v_o = 01,10,01,10.
//  3 req0 valid, mem_cmd_ready_i=0 for 4 cycles, req1 raises valid at cycle 2 -> mem_cmd_o stays
//    req0's message. req0 transfers on cycle 5, then req1 is granted.
//  4 8 cmds issued with no responses -> the 9th is blocked (mem_cmd_v_o=0). On the cycle a response
//    pops, the 9th is still blocked; it transfers the next cycle.
//  5 mem_resp_v_i=1 with FIFO empty -> mem_resp_yumi_o=0, req_resp_v_o=00, assertion reported.
//  6 Response for req1 at head, req1 yumi held low 3 cycles while req0 yumi=1 -> no pop.
//    Pop occurs on the first req1 yumi.

Source files
------------

// File: rtl/bp_me_pkg.sv
// Shared types and helpers for the BedRock lite memory command arbiter.
package bp_me_pkg;

   // Arbiter FSM: IDLE arbitrates every cycle, LOCK holds a grant the memory stalled.
   typedef enum logic {
      e_arb_idle = 1'b0,
      e_arb_lock = 1'b1
   } bp_me_arb_state_e;

   // Index width that never collapses to zero bits, so degenerate sizes still elaborate.
   function automatic int unsigned safe_clog2(input int unsigned n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/bp_me_arb_order_fifo.sv
// Order FIFO of granted requester IDs. One push and one pop per cycle; the head
// entry is the owner of the oldest outstanding memory command.
module bp_me_arb_order_fifo
   import bp_me_pkg::*;
#(
   parameter  int unsigned depth_p  = 8,
   parameter  int unsigned width_p  = 1,
   localparam int unsigned ptr_w_lp = safe_clog2(depth_p),
   localparam int unsigned cnt_w_lp = $clog2(depth_p + 1)
) (
   input  logic                clk_i,
   input  logic                reset_n_i,
   input  logic                push_i,
   input  logic [width_p-1:0]  data_i,
   input  logic                pop_i,
   output logic [width_p-1:0]  data_o,
   output logic                full_o,
   output logic                empty_o,
   output logic [cnt_w_lp-1:0] count_o
);

   logic [width_p-1:0]  mem_q [depth_p];
   logic [width_p-1:0]  mem_d [depth_p];
   logic [ptr_w_lp-1:0] wptr_q, wptr_d;
   logic [ptr_w_lp-1:0] rptr_q, rptr_d;
   logic [cnt_w_lp-1:0] count_q, count_d;
   logic                push_ok, pop_ok;

   // Pointers advance one slot and wrap after the last entry.
   function automatic logic [ptr_w_lp-1:0] ptr_inc(input logic [ptr_w_lp-1:0] p);
      return (p == ptr_w_lp'(depth_p - 1)) ? '0 : p + 1'b1;
   endfunction

   assign full_o  = (count_q == cnt_w_lp'(depth_p));
   assign empty_o = (count_q == '0);
   assign count_o = count_q;
   assign data_o  = mem_q[rptr_q];

   // Pushes into a full FIFO and pops from an empty one are dropped.
   assign push_ok = push_i & ~full_o;
   assign pop_ok  = pop_i & ~empty_o;

   // Next-state for storage, pointers and occupancy.
   always_comb begin
      mem_d   = mem_q;
      wptr_d  = wptr_q;
      rptr_d  = rptr_q;
      count_d = count_q;
      if (push_ok) begin
         mem_d[wptr_q] = data_i;
         wptr_d        = ptr_inc(wptr_q);
      end
      if (pop_ok) begin
         rptr_d = ptr_inc(rptr_q);
      end
      if (push_ok && !pop_ok) begin
         count_d = count_q + cnt_w_lp'(1);
      end else if (!push_ok && pop_ok) begin
         count_d = count_q - cnt_w_lp'(1);
      end
   end

   // State registers, cleared asynchronously.
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         for (int i = 0; i < int'(depth_p); i++) begin
            mem_q[i] <= '0;
         end
         wptr_q  <= '0;
         rptr_q  <= '0;
         count_q <= '0;
      end else begin
         mem_q   <= mem_d;
         wptr_q  <= wptr_d;
         rptr_q  <= rptr_d;
         count_q <= count_d;
      end
   end

   a_no_push_full: assert property (@(posedge clk_i) disable iff (!reset_n_i)
      !(push_i && full_o));
   a_no_pop_empty: assert property (@(posedge clk_i) disable iff (!reset_n_i)
      !(pop_i && empty_o));

endmodule

// File: rtl/bp_me_mem_cmd_arbiter.sv
// Shares one BedRock lite memory port between num_req_p command sources.
// Commands are arbitrated round-robin; granted IDs are queued so the in-order
// memory responses are steered back to the requester that issued them.
//
// Handshakes: every *_v / *_ready pair transfers on the cycle both are 1, and a
// source holding valid must keep it until the transfer. Response channels use
// valid/yumi: yumi is a same-cycle consume and may only be raised with valid.
module bp_me_mem_cmd_arbiter
   import bp_me_pkg::*;
#(
   parameter  int unsigned msg_width_p       = 1,
   parameter  int unsigned num_req_p         = 2,
   parameter  int unsigned max_outstanding_p = 8,
   localparam int unsigned id_w_lp           = safe_clog2(num_req_p),
   localparam int unsigned cnt_w_lp          = $clog2(max_outstanding_p + 1)
) (
   input  logic                             clk_i,
   input  logic                             reset_n_i,
   input  logic [num_req_p*msg_width_p-1:0] req_cmd_i,
   input  logic [num_req_p-1:0]             req_cmd_v_i,
   output logic [num_req_p-1:0]             req_cmd_ready_o,
   output logic [msg_width_p-1:0]           req_resp_o,
   output logic [num_req_p-1:0]             req_resp_v_o,
   input  logic [num_req_p-1:0]             req_resp_yumi_i,
   output logic [msg_width_p-1:0]           mem_cmd_o,
   output logic                             mem_cmd_v_o,
   input  logic                             mem_cmd_ready_i,
   input  logic [msg_width_p-1:0]           mem_resp_i,
   input  logic                             mem_resp_v_i,
   output logic                             mem_resp_yumi_o,
   output bp_me_arb_state_e                 arb_state_o
);

   bp_me_arb_state_e    state_q, state_d;
   logic [id_w_lp-1:0]  lock_id_q, lock_id_d;
   logic [id_w_lp-1:0]  rr_q, rr_d;

   logic                pick_v;
   logic [id_w_lp-1:0]  pick_id;
   logic                grant_v;
   logic [id_w_lp-1:0]  grant_id;
   logic                xfer;

   logic                fifo_full, fifo_empty;
   logic [id_w_lp-1:0]  head_id;
   logic [cnt_w_lp-1:0] fifo_count;
   logic                resp_v;

   // Requester IDs wrap at num_req_p-1, which need not be a power of two.
   function automatic logic [id_w_lp-1:0] id_inc(input logic [id_w_lp-1:0] id);
      return (id == id_w_lp'(num_req_p - 1)) ? '0 : id + 1'b1;
   endfunction

   // Round-robin pick: first valid requester at or after the rr pointer.
   always_comb begin
      logic [id_w_lp-1:0] cand;
      pick_v  = 1'b0;
      pick_id = '0;
      cand    = rr_q;
      for (int i = 0; i < int'(num_req_p); i++) begin
         if (!pick_v && req_cmd_v_i[cand]) begin
            pick_v  = 1'b1;
            pick_id = cand;
         end
         cand = id_inc(cand);
      end
   end

   // Arbiter FSM: grant selection, lock on memory stall, rr pointer update.
   always_comb begin
      state_d   = state_q;
      lock_id_d = lock_id_q;
      rr_d      = rr_q;
      grant_v   = 1'b0;
      grant_id  = '0;
      case (state_q)
         e_arb_idle: begin
            // A full order FIFO blocks new grants, so LOCK is never entered while full.
            if (pick_v && !fifo_full) begin
               grant_v  = 1'b1;
               grant_id = pick_id;
               if (!mem_cmd_ready_i) begin
                  state_d   = e_arb_lock;
                  lock_id_d = pick_id;
               end
            end
         end
         e_arb_lock: begin
            // The stalled grant stays selected until memory accepts it.
            grant_v  = 1'b1;
            grant_id = lock_id_q;
            if (mem_cmd_ready_i) begin
               state_d = e_arb_idle;
            end
         end
         default: state_d = e_arb_idle;
      endcase
      // Outputs are forced quiet for as long as reset is held.
      grant_v = grant_v & reset_n_i;
      xfer    = grant_v & mem_cmd_ready_i;
      if (xfer) begin
         rr_d = id_inc(grant_id);
      end
   end

   // Command path: granted message straight through, ready only on the transfer.
   always_comb begin
      mem_cmd_v_o     = grant_v;
      mem_cmd_o       = grant_v ? req_cmd_i[grant_id*msg_width_p +: msg_width_p] : '0;
      req_cmd_ready_o = '0;
      for (int r = 0; r < int'(num_req_p); r++) begin
         req_cmd_ready_o[r] = xfer && (grant_id == id_w_lp'(r));
      end
   end

   // Response path: steer the memory response to the FIFO head owner.
   always_comb begin
      resp_v          = mem_resp_v_i & ~fifo_empty & reset_n_i;
      req_resp_o      = reset_n_i ? mem_resp_i : '0;
      req_resp_v_o    = '0;
      for (int r = 0; r < int'(num_req_p); r++) begin
         req_resp_v_o[r] = resp_v && (head_id == id_w_lp'(r));
      end
      mem_resp_yumi_o = resp_v & req_resp_yumi_i[head_id];
   end

   // FSM, lock and round-robin registers.
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         state_q   <= e_arb_idle;
         lock_id_q <= '0;
         rr_q      <= '0;
      end else begin
         state_q   <= state_d;
         lock_id_q <= lock_id_d;
         rr_q      <= rr_d;
      end
   end

   assign arb_state_o = state_q;

   bp_me_arb_order_fifo #(
      .depth_p (max_outstanding_p),
      .width_p (id_w_lp)
   ) order_fifo (
      .clk_i     (clk_i),
      .reset_n_i (reset_n_i),
      .push_i    (xfer),
      .data_i    (grant_id),
      .pop_i     (mem_resp_yumi_o),
      .data_o    (head_id),
      .full_o    (fifo_full),
      .empty_o   (fifo_empty),
      .count_o   (fifo_count)
   );

   a_lock_hold: assert property (@(posedge clk_i) disable iff (!reset_n_i)
      (state_q == e_arb_lock) |-> req_cmd_v_i[lock_id_q]);
   a_lock_not_full: assert property (@(posedge clk_i) disable iff (!reset_n_i)
      (state_q == e_arb_lock) |-> !fifo_full);
   a_count_bound: assert property (@(posedge clk_i) disable iff (!reset_n_i)
      fifo_count <= cnt_w_lp'(max_outstanding_p));
   a_yumi_match: assert property (@(posedge clk_i) disable iff (!reset_n_i)
      (req_resp_yumi_i & ~req_resp_v_o) == '0)
      else $warning("req_resp_yumi_i raised without matching req_resp_v_o");
   a_resp_not_empty: assert property (@(posedge clk_i) disable iff (!reset_n_i)
      !(mem_resp_v_i && fifo_empty))
      else $warning("mem_resp_v_i with no outstanding command");

endmodule

// File: tb/tb_bp_me_mem_cmd_arbiter.sv
// Testbench for bp_me_mem_cmd_arbiter: directed scenarios plus randomized traffic,
// all checked against a queue-based reference model of the arbitration rules.
module tb_bp_me_mem_cmd_arbiter;
   import bp_me_pkg::*;

   localparam int W    = 16;
   localparam int N    = 2;
   localparam int MAX  = 8;
   localparam int ID_W = $clog2(N);
   localparam int VW   = 1 + W + N + N + 1 + W;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   always #5 clk = ~clk;
   logic rst_n;

   // ---------------- DUT signals ----------------
   logic [W-1:0]   req_msg [N];
   logic [N*W-1:0] req_cmd;
   logic [N-1:0]   req_cmd_v, req_cmd_ready, req_resp_v, req_resp_yumi;
   logic [W-1:0]   req_resp, mem_cmd, mem_resp;
   logic           mem_cmd_v, mem_cmd_ready, mem_resp_v, mem_resp_yumi;
   bp_me_arb_state_e arb_state;

   always_comb begin
      req_cmd = '0;
      for (int r = 0; r < N; r++) req_cmd[r*W +: W] = req_msg[r];
   end

   bp_me_mem_cmd_arbiter #(
      .msg_width_p       (W),
      .num_req_p         (N),
      .max_outstanding_p (MAX)
   ) dut (
      .clk_i           (clk),
      .reset_n_i       (rst_n),
      .req_cmd_i       (req_cmd),
      .req_cmd_v_i     (req_cmd_v),
      .req_cmd_ready_o (req_cmd_ready),
      .req_resp_o      (req_resp),
      .req_resp_v_o    (req_resp_v),
      .req_resp_yumi_i (req_resp_yumi),
      .mem_cmd_o       (mem_cmd),
      .mem_cmd_v_o     (mem_cmd_v),
      .mem_cmd_ready_i (mem_cmd_ready),
      .mem_resp_i      (mem_resp),
      .mem_resp_v_i    (mem_resp_v),
      .mem_resp_yumi_o (mem_resp_yumi),
      .arb_state_o     (arb_state)
   );

   // ---------------- reference model / scoreboard ----------------
   int checks   = 0;
   int failures = 0;
   logic [ID_W-1:0] exp_q [$];   // owners of outstanding commands, oldest first
   int   rr_m;                   // next requester to favour
   int   lock_m;                 // requester whose grant is pending, -1 if none
   logic           e_cmd_v, e_yumi;
   logic [W-1:0]   e_cmd, e_resp;
   logic [N-1:0]   e_ready, e_resp_v;
   int             e_grant;

   function automatic void model_reset();
      rr_m   = 0;
      lock_m = -1;
      exp_q.delete();
   endfunction

   // Expected outputs for the current inputs and model state.
   function automatic void model_eval();
      int g;
      g        = -1;
      e_cmd_v  = 1'b0;
      e_cmd    = '0;
      e_ready  = '0;
      e_resp_v = '0;
      e_yumi   = 1'b0;
      e_resp   = '0;
      e_grant  = 0;
      if (rst_n) begin
         if (lock_m >= 0) g = lock_m;
         else if (exp_q.size() < MAX) begin
            for (int i = 0; i < N; i++) begin
               int c;
               c = (rr_m + i) % N;
               if (g < 0 && req_cmd_v[c]) g = c;
            end
         end
         if (g >= 0) begin
            e_cmd_v = 1'b1;
            e_grant = g;
            e_cmd   = req_msg[g];
            if (mem_cmd_ready) e_ready[g] = 1'b1;
         end
         e_resp = mem_resp;
         if (mem_resp_v && exp_q.size() > 0) begin
            e_resp_v[exp_q[0]] = 1'b1;
            e_yumi             = req_resp_yumi[exp_q[0]];
         end
      end
   endfunction

   // Apply the clock edge to the model using the last evaluation.
   function automatic void model_commit();
      if (e_cmd_v && mem_cmd_ready) begin
         exp_q.push_back(ID_W'(e_grant));
         rr_m   = (e_grant + 1) % N;
         lock_m = -1;
      end else if (e_cmd_v) begin
         lock_m = e_grant;
      end
      if (e_yumi) void'(exp_q.pop_front());
   endfunction

   function automatic logic [VW-1:0] exp_vec();
      return {e_cmd_v, e_cmd, e_ready, e_resp_v, e_yumi, e_resp};
   endfunction

   function automatic logic [VW-1:0] dut_vec();
      return {mem_cmd_v, mem_cmd, req_cmd_ready, req_resp_v, mem_resp_yumi, req_resp};
   endfunction

   // ---------------- driver tasks ----------------
   task automatic clear_inputs();
      req_cmd_v     = '0;
      req_resp_yumi = '0;
      mem_cmd_ready = 1'b0;
      mem_resp_v    = 1'b0;
      mem_resp      = W'($urandom);
      for (int r = 0; r < N; r++) req_msg[r] = W'($urandom);
   endtask

   // Settle the current inputs and compute the model's expectation.
   task automatic settle();
      #2;
      model_eval();
   endtask

   // Commit this cycle and move to just after the next rising edge.
   task automatic advance();
      model_commit();
      @(posedge clk);
      #1;
   endtask

   // Return every outstanding response to its owner.
   task automatic drain();
      for (int k = 0; k < MAX + 2 && exp_q.size() > 0; k++) begin
         clear_inputs();
         mem_resp_v    = 1'b1;
         req_resp_yumi = '0;
         req_resp_yumi[exp_q[0]] = 1'b1;
         settle();
         advance();
      end
      clear_inputs();
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      rst_n = 1'b0;
      clear_inputs();
      req_cmd_v     = '1;
      mem_cmd_ready = 1'b1;
      mem_resp_v    = 1'b1;
      req_resp_yumi = '0;
      model_reset();
      settle();
      checks++;
      if (dut_vec() !== '0)
         begin failures++; $display("FAIL reset_outputs: got %h expected 0", dut_vec()); end
      checks++;
      if (arb_state !== e_arb_idle)
         begin failures++; $display("FAIL reset_state: got %0d expected %0d", arb_state, e_arb_idle); end
      @(posedge clk); #1;
      clear_inputs();
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_reset_mid_lock();
      // Three commands from req0, then a stalled fourth that locks.
      for (int c = 0; c < 4; c++) begin
         clear_inputs();
         req_cmd_v[0] = 1'b1;
         mem_cmd_ready = (c < 3);
         settle();
         checks++;
         if (dut_vec() !== exp_vec())
            begin failures++; $display("FAIL midlock_issue%0d: got %h expected %h", c, dut_vec(), exp_vec()); end
         advance();
      end
      req_cmd_v[0] = 1'b1;
      mem_cmd_ready = 1'b0;
      mem_resp_v = 1'b1;
      #1;
      checks++;
      if (arb_state !== e_arb_lock)
         begin failures++; $display("FAIL midlock_state: got %0d expected %0d", arb_state, e_arb_lock); end
      rst_n = 1'b0;
      #1;
      checks++;
      if (dut_vec() !== '0)
         begin failures++; $display("FAIL midlock_async_outputs: got %h expected 0", dut_vec()); end
      checks++;
      if (arb_state !== e_arb_idle)
         begin failures++; $display("FAIL midlock_async_state: got %0d expected %0d", arb_state, e_arb_idle); end
      model_reset();
      @(posedge clk); #1;
      clear_inputs();
      @(posedge clk); #1;
      rst_n = 1'b1;
      // Memory asserting a response now must find nothing outstanding.
      mem_resp_v = 1'b1;
      settle();
      checks++;
      if (req_resp_v !== 2'b00 || mem_resp_yumi !== 1'b0)
         begin failures++; $display("FAIL midlock_empty_after: got v=%b yumi=%b expected v=00 yumi=0", req_resp_v, mem_resp_yumi); end
      advance();
      clear_inputs();
      req_cmd_v[1] = 1'b1;
      mem_cmd_ready = 1'b1;
      settle();
      checks++;
      if (req_cmd_ready !== 2'b10 || mem_cmd !== req_msg[1])
         begin failures++; $display("FAIL midlock_req1_first: got ready=%b cmd=%h expected ready=10 cmd=%h", req_cmd_ready, mem_cmd, req_msg[1]); end
      advance();
      drain();
   endtask

   task automatic test_round_robin();
      logic [N-1:0] seq [4];
      seq[0] = 2'b01; seq[1] = 2'b10; seq[2] = 2'b01; seq[3] = 2'b10;
      for (int c = 0; c < 4; c++) begin
         clear_inputs();
         req_cmd_v     = '1;
         mem_cmd_ready = 1'b1;
         settle();
         checks++;
         if (req_cmd_ready !== seq[c] || dut_vec() !== exp_vec())
            begin failures++; $display("FAIL rr_grant%0d: got ready=%b vec=%h expected ready=%b vec=%h", c, req_cmd_ready, dut_vec(), seq[c], exp_vec()); end
         advance();
      end
      for (int c = 0; c < 4; c++) begin
         clear_inputs();
         mem_resp_v    = 1'b1;
         req_resp_yumi = seq[c];
         settle();
         checks++;
         if (req_resp_v !== seq[c] || dut_vec() !== exp_vec())
            begin failures++; $display("FAIL rr_resp%0d: got v=%b vec=%h expected v=%b vec=%h", c, req_resp_v, dut_vec(), seq[c], exp_vec()); end
         advance();
      end
      drain();
   endtask

   task automatic test_lock_hold();
      logic [W-1:0] msg0;
      clear_inputs();
      msg0 = req_msg[0];
      for (int c = 1; c <= 6; c++) begin
         req_cmd_v[0]  = (c <= 5);
         req_cmd_v[1]  = (c >= 2);
         mem_cmd_ready = (c >= 5);
         req_msg[1]    = W'($urandom);
         settle();
         checks++;
         if (dut_vec() !== exp_vec())
            begin failures++; $display("FAIL lock_cycle%0d: got %h expected %h", c, dut_vec(), exp_vec()); end
         if (c <= 5) begin
            checks++;
            if (mem_cmd !== msg0 || mem_cmd_v !== 1'b1)
               begin failures++; $display("FAIL lock_msg%0d: got v=%b cmd=%h expected v=1 cmd=%h", c, mem_cmd_v, mem_cmd, msg0); end
         end
         if (c == 5) begin
            checks++;
            if (req_cmd_ready !== 2'b01)
               begin failures++; $display("FAIL lock_release: got ready=%b expected 01", req_cmd_ready); end
         end
         if (c == 6) begin
            checks++;
            if (req_cmd_ready !== 2'b10)
               begin failures++; $display("FAIL lock_next_req1: got ready=%b expected 10", req_cmd_ready); end
         end
         advance();
      end
      drain();
   endtask

   task automatic test_full_block();
      for (int c = 0; c < MAX + 3; c++) begin
         clear_inputs();
         req_cmd_v[0]  = 1'b1;
         mem_cmd_ready = 1'b1;
         if (c == MAX + 1) begin
            mem_resp_v       = 1'b1;
            req_resp_yumi[0] = 1'b1;
         end
         settle();
         checks++;
         if (dut_vec() !== exp_vec())
            begin failures++; $display("FAIL full_cycle%0d: got %h expected %h", c, dut_vec(), exp_vec()); end
         if (c == MAX || c == MAX + 1) begin
            checks++;
            if (mem_cmd_v !== 1'b0 || req_cmd_ready !== 2'b00)
               begin failures++; $display("FAIL full_blocked%0d: got v=%b ready=%b expected v=0 ready=00", c, mem_cmd_v, req_cmd_ready); end
         end
         if (c == MAX + 1) begin
            checks++;
            if (mem_resp_yumi !== 1'b1)
               begin failures++; $display("FAIL full_pop: got yumi=%b expected 1", mem_resp_yumi); end
         end
         if (c == MAX + 2) begin
            checks++;
            if (req_cmd_ready !== 2'b01)
               begin failures++; $display("FAIL full_unblock: got ready=%b expected 01", req_cmd_ready); end
         end
         advance();
      end
      drain();
   endtask

   task automatic test_resp_empty();
      clear_inputs();
      mem_resp_v = 1'b1;
      settle();
      checks++;
      if (mem_resp_yumi !== 1'b0 || req_resp_v !== 2'b00)
         begin failures++; $display("FAIL resp_empty: got yumi=%b v=%b expected yumi=0 v=00", mem_resp_yumi, req_resp_v); end
      advance();
      clear_inputs();
   endtask

   task automatic test_yumi_head();
      clear_inputs();
      req_cmd_v[1]  = 1'b1;
      mem_cmd_ready = 1'b1;
      settle();
      checks++;
      if (req_cmd_ready !== 2'b10)
         begin failures++; $display("FAIL yumi_issue: got ready=%b expected 10", req_cmd_ready); end
      advance();
      for (int c = 0; c < 4; c++) begin
         clear_inputs();
         mem_resp_v    = 1'b1;
         req_resp_yumi = (c < 3) ? 2'b01 : 2'b10;
         settle();
         checks++;
         if (req_resp_v !== 2'b10 || mem_resp_yumi !== (c == 3) || req_resp !== mem_resp)
            begin failures++; $display("FAIL yumi_head%0d: got v=%b yumi=%b resp=%h expected v=10 yumi=%b resp=%h", c, req_resp_v, mem_resp_yumi, req_resp, (c == 3), mem_resp); end
         advance();
      end
      clear_inputs();
      drain();
   endtask

   task automatic test_random();
      for (int c = 0; c < 400; c++) begin
         clear_inputs();
         req_cmd_v = N'($urandom_range(0, (1 << N) - 1));
         if (lock_m >= 0) req_cmd_v[lock_m] = 1'b1;
         mem_cmd_ready = ($urandom_range(0, 3) != 0);
         if (exp_q.size() > 0 && $urandom_range(0, 2) != 0) begin
            mem_resp_v = 1'b1;
            if ($urandom_range(0, 3) != 0) req_resp_yumi[exp_q[0]] = 1'b1;
         end
         settle();
         checks++;
         if (dut_vec() !== exp_vec())
            begin failures++; $display("FAIL random%0d: got %h expected %h", c, dut_vec(), exp_vec()); end
         advance();
      end
      // Let any pending grant complete before draining responses.
      if (lock_m >= 0) begin
         clear_inputs();
         req_cmd_v[lock_m] = 1'b1;
         mem_cmd_ready = 1'b1;
         settle();
         advance();
      end
      drain();
   endtask

   // ---------------- watchdog ----------------
   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
      $fatal(1, "timeout");
   end

   // ---------------- sequence and report ----------------
   initial begin
      rst_n = 1'b0;
      clear_inputs();
      model_reset();
      test_reset();
      test_reset_mid_lock();
      test_round_robin();
      test_lock_hold();
      test_full_block();
      test_resp_empty();
      test_yumi_head();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
